// File: rtl/booth_mult_radix4_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM encoding, digit codes, decode helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package booth_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_CALC = CALC,
    S_DONE = DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // Each iteration retires two multiplier bits of the 2-bit-extended operand.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

  function automatic digit_t booth_decode(input logic [2:0] trip);
    digit_t d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mult_radix4_if.sv
// Operand/result handshake bundle for booth_mult_radix4.
// Start accepted only while ready is high; done is a one-cycle result strobe.
interface booth_mult_radix4_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    en_i_mult;
  logic                    signed_i_mult;
  logic [DATA_WIDTH-1:0]   A;
  logic [DATA_WIDTH-1:0]   B;
  logic                    ready_o_mult;
  logic [2*DATA_WIDTH-1:0] result_o_mult;
  logic                    mult_done_o;

  modport master (
    output en_i_mult, signed_i_mult, A, B,
    input  ready_o_mult, result_o_mult, mult_done_o
  );

  modport slave (
    input  en_i_mult, signed_i_mult, A, B,
    output ready_o_mult, result_o_mult, mult_done_o
  );
endinterface

// File: rtl/booth_mult_radix4_r4_digit.sv
// Radix-4 Booth partial-product generator: triplet selects 0, +-M or +-2M.
// Purely combinational, zero latency, no flow control.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic        [2:0]            i_trip,
  input  logic signed [DATA_WIDTH+1:0] i_m,
  output logic signed [DATA_WIDTH+3:0] o_pp
);

  localparam int PW = DATA_WIDTH + 4;

  logic signed [PW-1:0] w_m1;
  logic signed [PW-1:0] w_m2;
  digit_t               w_digit;

  assign w_m1    = {{2{i_m[DATA_WIDTH+1]}}, i_m};
  assign w_m2    = w_m1 <<< 1;
  assign w_digit = booth_decode(i_trip);

  always_comb begin
    o_pp = '0;
    case (w_digit)
      POS1:    o_pp = w_m1;
      POS2:    o_pp = w_m2;
      NEG1:    o_pp = -w_m1;
      NEG2:    o_pp = -w_m2;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_radix4.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation, full-width product.
// Latency DATA_WIDTH/2+2 edges from acceptance; starts ignored (not queued) while busy.
module booth_mult_radix4
  import booth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH/2 + 2)
) (
  input  logic               clk_i_mult,
  input  logic               rstn_i_mult,
  booth_mult_radix4_if.slave bus
);

  localparam int PW  = DATA_WIDTH + 4;
  localparam int QW  = DATA_WIDTH + 3;
  localparam int NIT = booth_iters(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIT - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic signed [PW-1:0]        r_p;
  logic        [QW-1:0]        r_q;
  logic signed [DATA_WIDTH+1:0] r_m;
  logic        [CNT_W-1:0]     r_cnt;
  logic [2*DATA_WIDTH-1:0]     r_result;
  logic                        r_done;

  logic                        w_ext_a;
  logic                        w_ext_b;
  logic signed [PW-1:0]        w_pp;
  logic signed [PW-1:0]        w_psum;
  logic signed [PW+QW-1:0]     w_shift;

  assign w_ext_a = bus.signed_i_mult & bus.A[DATA_WIDTH-1];
  assign w_ext_b = bus.signed_i_mult & bus.B[DATA_WIDTH-1];

  booth_r4_digit #(.DATA_WIDTH(DATA_WIDTH)) u_digit (
    .i_trip (r_q[2:0]),
    .i_m    (r_m),
    .o_pp   (w_pp)
  );

  // Accumulate then shift {P,Q} right by two as one signed word.
  assign w_psum  = r_p + w_pp;
  assign w_shift = $signed({w_psum, r_q}) >>> 2;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.en_i_mult) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i_mult or negedge rstn_i_mult) begin
    if (!rstn_i_mult) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i_mult or negedge rstn_i_mult) begin
    if (!rstn_i_mult) begin
      r_p      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.en_i_mult) begin
            r_m   <= {{2{w_ext_b}}, bus.B};
            r_q   <= {{2{w_ext_a}}, bus.A, 1'b0};
            r_p   <= '0;
            r_cnt <= '0;
          end
        end
        S_CALC: begin
          r_p   <= w_shift[PW+QW-1:QW];
          r_q   <= w_shift[QW-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          // Low product bits were shifted into the top of Q; the rest sit at the bottom of P.
          r_result <= {r_p[DATA_WIDTH-3:0], r_q[QW-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o_mult  = (r_state == S_IDLE);
  assign bus.result_o_mult = r_result;
  assign bus.mult_done_o   = r_done;

endmodule

// File: doc/booth_mult_radix4.md
# booth_mult_radix4

Sequential radix-4 (modified) Booth multiplier; parametrised successor of the radix-2 unsigned Booth unit used in the contrast-stretching datapath. Accepts two DATA_WIDTH operands, either unsigned or two's-complement as selected per operation, and returns the full 2·DATA_WIDTH product. It takes DATA_WIDTH/2+1 iteration cycles instead of DATA_WIDTH+1, and has an explicit ready/done handshake. It sits between pixel-scaling logic and the downstream divider.

## Interface
- DATA_WIDTH, 8, operand width; even, ≥ 4.
- CNT_W, $clog2(DATA_WIDTH/2+2), iteration counter width. Derived; do not override.

- clk_i_mult  in  1  clock; all state changes on the rising edge.
- rstn_i_mult  in  1  asynchronous, active-low reset.
- en_i_mult  in  1  start request. Accepted only when ready_o_mult=1.
- signed_i_mult  in  1  1 = A and B are two's-complement; 0 = unsigned. Sampled at acceptance.
- A  in  DATA_WIDTH  multiplier operand, sampled at acceptance.
- B  in  DATA_WIDTH  multiplicand operand, sampled at acceptance.
- ready_o_mult  out  1  high when the block is in IDLE. Decoded from the state register.
- result_o_mult  out  2·DATA_WIDTH  product, registered; holds its value until the next done.
- mult_done_o  out  1  one-cycle pulse when result_o_mult updates.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on en_i_mult=1. On that edge:
  - Capture M = B extended to DATA_WIDTH+2 bits: sign-extended if signed_i_mult=1, zero-extended otherwise.
  - Capture Q = {A extended to DATA_WIDTH+2 bits, 1'b0}, using the same extension rule; the appended bit is q[-1].
  - Clear the accumulator P (DATA_WIDTH+4 bits, signed) and clear the counter.
- CALC, one radix-4 step per cycle:
  - Triplet {q1,q0,q-1} = Q[2:0] selects the digit: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - P ← P + digit·M, then arithmetic-shift {P,Q} right by 2.
  - Counter increments each step. After step DATA_WIDTH/2+1 (counter = DATA_WIDTH/2), go to DONE.
- DONE: result_o_mult ← low 2·DATA_WIDTH bits of the concatenated {P,Q[high part]} product; mult_done_o ← 1; go to IDLE.
- Result is exact for all operand pairs in both modes. The unsigned max 0xFF·0xFF = 0xFE01 fits because of the 2-bit extension.
- en_i_mult while not ready is ignored. It is not queued.
- Changes on A, B or signed_i_mult during CALC/DONE have no effect.
- Reset, including mid-operation: state=IDLE, P/Q/counter=0, result_o_mult=0, mult_done_o=0, ready_o_mult=1. No partial result escapes.

## Timing
- Acceptance at edge k. CALC steps occur at edges k+1 … k+DATA_WIDTH/2+1. DONE executes at edge k+DATA_WIDTH/2+2.
- mult_done_o is high for exactly the one cycle after edge k+DATA_WIDTH/2+2; result_o_mult is valid from that edge.
- Latency DATA_WIDTH/2+2 edges (DATA_WIDTH=8 → 6).
- ready_o_mult is low from edge k+1 until edge k+DATA_WIDTH/2+2.
- Back-to-back: en_i_mult held high is accepted in the cycle that mult_done_o is high. Minimum issue interval is DATA_WIDTH/2+3 cycles.
- mult_done_o is deasserted on every edge where the state is not DONE.

## Structure
- Package booth_pkg holds:
  - State encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - Booth digit codes (ZERO, POS1, POS2, NEG1, NEG2).
  - A function returning the iteration count for a given width.
- One sub-module, booth_r4_digit. It is combinational:
  - Inputs: the triplet and M.
  - Output: the signed DATA_WIDTH+4 partial product (0, ±M, ±2M via shift and two's-complement).
- The top module owns the FSM, counter, shift registers and output registers.

## Test plan
- DATA_WIDTH=8, unsigned: A=0xFF, B=0xFF → result 0xFE01. mult_done_o pulses exactly once, 6 edges after acceptance.
- Signed: A=0x80 (−128), B=0x80 → 0x4000. A=0x7F, B=0x80 → 0xC080 (−16256). A=0xFF (−1), B=0x01 → 0xFFFF.
- Same bits, unsigned vs signed: A=0xFF, B=0x01 unsigned → 0x00FF, signed → 0xFFFF.
- Handshake:
  - en_i_mult held high continuously with new operands per accept: results 3·5=15, then 0·200=0. Issue interval 7 cycles.
  - Operands changed during CALC do not alter the result.
  - Pulses of en_i_mult during busy are ignored.
- Reset: assert rstn_i_mult at the 3rd CALC cycle. All outputs read 0 and ready_o_mult=1 immediately. The next operation 10·10 returns 100 with no stale done.
- Random: 10k random A, B and mode at DATA_WIDTH=8 and 16, compared against a reference product computed at double width.
